// File: rtl/fir_mac_seq.sv
// FIR MAC sequencer: writes each new sample into the circular delay line,
// walks the taps, times the accumulator controls and loads the output.
module fir_mac_seq #(
  parameter int NTAPS   = 16,
  parameter int ADDR_W  = 4,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st,
  input  logic              en,
  input  logic              ovr_clr,
  output logic              smp_we,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] dl_addr,
  output logic [ADDR_W-1:0] co_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              y_ld,
  output logic              busy,
  output logic              ovr
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] NT       = ADDR_W'(NTAPS);
  localparam logic [DW-1:0]     LAST_DR  = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_MAC,
    S_DRAIN,
    S_LOAD
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   k_q;
  logic [DW-1:0]       dr_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   dl_addr_q;
  logic [ADDR_W-1:0]   co_addr_q;
  logic [ADDR_W-1:0]   dl_d;
  logic [MAC_LAT:0]    vld_q;
  logic                smp_we_q;
  logic                acc_clr_q;
  logic                y_ld_q;
  logic                busy_q;
  logic                ovr_q;

  // Delay-line read address for tap k: newest sample minus k, wrapped mod NTAPS.
  always_comb begin
    dl_d = '0;
    if (wr_ptr_q >= k_q) dl_d = wr_ptr_q - k_q;
    else                 dl_d = wr_ptr_q + NT - k_q;
  end

  // Sequencer FSM; outputs are registered decodes of the state one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      dr_q      <= '0;
      wr_ptr_q  <= '0;
      dl_addr_q <= '0;
      co_addr_q <= '0;
      vld_q     <= '0;
      smp_we_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      y_ld_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      smp_we_q  <= (state_q == S_WRITE);
      acc_clr_q <= (state_q == S_WRITE);
      y_ld_q    <= (state_q == S_LOAD);
      busy_q    <= (state_q != S_IDLE);
      vld_q     <= {vld_q[MAC_LAT-1:0], (state_q == S_MAC)};
      if (st && (state_q != S_IDLE)) ovr_q <= 1'b1;
      else if (ovr_clr)              ovr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (st && en) state_q <= S_WRITE;
        end
        S_WRITE: begin
          dl_addr_q <= wr_ptr_q;
          co_addr_q <= '0;
          k_q       <= '0;
          state_q   <= S_MAC;
        end
        S_MAC: begin
          co_addr_q <= k_q;
          dl_addr_q <= dl_d;
          k_q       <= k_q + 1'b1;
          if (k_q == LAST_TAP) begin
            dr_q    <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          dr_q <= dr_q + 1'b1;
          if (dr_q == LAST_DR) state_q <= S_LOAD;
        end
        S_LOAD: begin
          wr_ptr_q <= (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign smp_we  = smp_we_q;
  assign wr_ptr  = wr_ptr_q;
  assign dl_addr = dl_addr_q;
  assign co_addr = co_addr_q;
  assign acc_clr = acc_clr_q;
  assign acc_en  = vld_q[MAC_LAT];
  assign y_ld    = y_ld_q;
  assign busy    = busy_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: default 16-tap instance plus a
// 5-tap, single-latency instance, checked cycle by cycle.
module tb_fir_mac_seq;

  logic clk;
  logic reset;
  logic st, en, ovr_clr;
  logic smp_we, acc_clr, acc_en, y_ld, busy, ovr;
  logic [3:0] wr_ptr, dl_addr, co_addr;

  logic b_st, b_en, b_ovr_clr;
  logic b_smp_we, b_acc_clr, b_acc_en, b_y_ld, b_busy, b_ovr;
  logic [2:0] b_wr_ptr, b_dl_addr, b_co_addr;

  int n_run  = 0;
  int n_fail = 0;
  int ld_cnt = 0;
  int ldb_cnt = 0;
  bit sel = 1'b0;

  logic m_we, m_clr, m_acc, m_ld, m_busy;
  logic [3:0] m_wp, m_dl, m_co;

  fir_mac_seq dut (
    .clk     (clk),
    .reset   (reset),
    .st      (st),
    .en      (en),
    .ovr_clr (ovr_clr),
    .smp_we  (smp_we),
    .wr_ptr  (wr_ptr),
    .dl_addr (dl_addr),
    .co_addr (co_addr),
    .acc_clr (acc_clr),
    .acc_en  (acc_en),
    .y_ld    (y_ld),
    .busy    (busy),
    .ovr     (ovr)
  );

  fir_mac_seq #(.NTAPS(5), .ADDR_W(3), .MAC_LAT(1)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .st      (b_st),
    .en      (b_en),
    .ovr_clr (b_ovr_clr),
    .smp_we  (b_smp_we),
    .wr_ptr  (b_wr_ptr),
    .dl_addr (b_dl_addr),
    .co_addr (b_co_addr),
    .acc_clr (b_acc_clr),
    .acc_en  (b_acc_en),
    .y_ld    (b_y_ld),
    .busy    (b_busy),
    .ovr     (b_ovr)
  );

  assign m_we   = sel ? b_smp_we  : smp_we;
  assign m_clr  = sel ? b_acc_clr : acc_clr;
  assign m_acc  = sel ? b_acc_en  : acc_en;
  assign m_ld   = sel ? b_y_ld    : y_ld;
  assign m_busy = sel ? b_busy    : busy;
  assign m_wp   = sel ? {1'b0, b_wr_ptr}  : wr_ptr;
  assign m_dl   = sel ? {1'b0, b_dl_addr} : dl_addr;
  assign m_co   = sel ? {1'b0, b_co_addr} : co_addr;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (y_ld)   ld_cnt++;
    if (b_y_ld) ldb_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sample sequence; st is sampled at the first edge (cycle 0).
  // st_a/st_b: extra strobes, clr_at: ovr_clr, en_off: en drop cycle.
  task automatic seq(input bit s, input int wp0, input int st_a,
                     input int st_b, input int clr_at, input int en_off);
    int t, l, last, k;
    sel = s;
    t = s ? 5 : 16;
    l = s ? 1 : 2;
    last = t + l + 2;
    if (s) b_st = 1'b1;
    else   st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    b_st = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      chk("smp_we", m_we, n == 1);
      chk("acc_clr", m_clr, n == 1);
      chk("acc_en", m_acc, (n >= 2 + l) && (n <= t + 1 + l));
      chk("y_ld", m_ld, n == last);
      chk("busy", m_busy, 1);
      if (n < last) chk("wr_ptr", m_wp, wp0);
      if (n == 1) chk("dl_wr", m_dl, wp0);
      if (n >= 2 && n <= t + 1) begin
        k = n - 2;
        chk("co_addr", m_co, k);
        chk("dl_addr", m_dl, (wp0 - k + t) % t);
      end
      st = !s && ((n + 1 == st_a) || (n + 1 == st_b));
      ovr_clr = (n + 1 == clr_at);
      if (en_off > 0 && n + 1 == en_off) en = 1'b0;
    end
    st = 1'b0;
    ovr_clr = 1'b0;
  endtask

  initial begin
    int l0;
    reset = 1'b1;
    st = 1'b0;
    en = 1'b1;
    ovr_clr = 1'b0;
    b_st = 1'b0;
    b_en = 1'b1;
    b_ovr_clr = 1'b0;
    #25;
    chk("rst_we", smp_we, 0);
    chk("rst_wp", wr_ptr, 0);
    chk("rst_dl", dl_addr, 0);
    chk("rst_co", co_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    reset = 1'b0;
    idle(1);

    // basic sequence from reset
    seq(0, 0, 0, 0, 0, 0);
    idle(1);
    chk("wp_after", wr_ptr, 1);
    chk("busy_after", busy, 0);

    // 20 samples at 50-cycle spacing, wrap 15->0
    l0 = ld_cnt;
    for (int i = 0; i < 20; i++) begin
      seq(0, (1 + i) % 16, 0, 0, 0, 0);
      idle(29);
    end
    chk("ld_count", ld_cnt - l0, 20);
    chk("ovr_none", ovr, 0);
    chk("wp_wrap", wr_ptr, 5);

    // overrun at cycle 10 and in LOAD, then accepted at 21
    seq(0, 5, 10, 20, 0, 0);
    chk("ovr_set", ovr, 1);
    seq(0, 6, 0, 0, 0, 0);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    chk("ovr_clr", ovr, 0);
    seq(0, 7, 5, 0, 5, 0);
    chk("ovr_set_wins", ovr, 1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    chk("ovr_clr2", ovr, 0);

    // asynchronous reset mid-sequence
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    idle(7);
    chk("pre_rst_busy", busy, 1);
    #5 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_wp", wr_ptr, 0);
    chk("ar_dl", dl_addr, 0);
    chk("ar_co", co_addr, 0);
    chk("ar_acc", acc_en, 0);
    chk("ar_ld", y_ld, 0);
    #2 reset = 1'b0;
    l0 = ld_cnt;
    idle(25);
    chk("ar_no_ld", ld_cnt - l0, 0);
    chk("ar_wp_hold", wr_ptr, 0);
    seq(0, 0, 0, 0, 0, 0);
    idle(1);

    // enable low: strobe ignored
    en = 1'b0;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      chk("dis_busy", busy, 0);
      chk("dis_we", smp_we, 0);
      idle(1);
    end
    chk("dis_ovr", ovr, 0);
    en = 1'b1;
    seq(0, 1, 0, 0, 0, 5);
    idle(1);
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    idle(3);
    chk("en_off_busy", busy, 0);
    chk("en_off_wp", wr_ptr, 2);
    en = 1'b1;

    // 5-tap, MAC_LAT=1 instance
    l0 = ldb_cnt;
    for (int i = 0; i < 7; i++) begin
      seq(1, i % 5, 0, 0, 0, 0);
      idle(5);
    end
    sel = 1'b0;
    chk("b_ld_count", ldb_cnt - l0, 7);
    chk("b_wp", b_wr_ptr, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
